// File: rtl/sysref_pkg.sv
// Shared types and helpers for the PL SYSREF qualification logic.
package sysref_pkg;

  typedef enum logic [2:0] {
    SR_IDLE,
    SR_SEEK,
    SR_MEASURE,
    SR_TRACK,
    SR_LOCKED
  } sr_state_t;

  localparam int SR_PERIOD_W   = 16;
  localparam int SR_LOCK_COUNT = 4;
  localparam int SR_TOL        = 1;

  // True when two intervals differ by no more than tol cycles.
  function automatic logic within_tol(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] tol);
    logic [31:0] d;
    d = (a > b) ? a - b : b - a;
    return d <= tol;
  endfunction

endpackage

// File: rtl/sysref_edge_det.sv
// Rising-edge detector and saturating since-last-edge counter for registered SYSREF.
module sysref_edge_det #(
  parameter int PERIOD_W = 16
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic                sysref_in,
  output logic                rise,
  output logic                edge_q,
  output logic [PERIOD_W-1:0] cnt
);

  logic sref_d;

  assign rise = sysref_in & ~sref_d;

  // sref_d resets high so a SYSREF already high at reset release is not an edge.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      sref_d <= 1'b1;
      edge_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sref_d <= sysref_in;
      edge_q <= rise;
      if (rise)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/sysref_monitor.sv
// SYSREF period qualification: lock after a run of consistent intervals, flag loss/irregularity.
module sysref_monitor
  import sysref_pkg::*;
#(
  parameter int PERIOD_W   = SR_PERIOD_W,
  parameter int LOCK_COUNT = SR_LOCK_COUNT,
  parameter int TOL        = SR_TOL
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic                sysref_in,
  input  logic                enable,
  input  logic                clear_err,
  output logic                sysref_edge,
  output logic                locked,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] phase,
  output logic                err_sticky,
  output logic [7:0]          edge_cnt
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  sr_state_t           state;
  logic [PERIOD_W-1:0] ref_p;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] interval;
  logic [MW-1:0]       match;
  logic                rise;
  logic                hit;
  logic                tmo;

  sysref_edge_det #(.PERIOD_W(PERIOD_W)) u_edge (
    .pl_clk    (pl_clk),
    .pl_rst    (pl_rst),
    .sysref_in (sysref_in),
    .rise      (rise),
    .edge_q    (sysref_edge),
    .cnt       (cnt)
  );

  assign interval = cnt + PERIOD_W'(1);
  assign hit      = within_tol(32'(interval), 32'(ref_p), 32'(TOL));
  assign tmo      = (cnt == '1) && (state inside {SR_MEASURE, SR_TRACK, SR_LOCKED});
  assign period   = ref_p;
  assign phase    = cnt;

  // A clear is applied first so any error raised in the same cycle overrides it.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      state      <= SR_IDLE;
      ref_p      <= '0;
      match      <= '0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      if (clear_err) err_sticky <= 1'b0;
      if (!enable) begin
        state  <= SR_IDLE;
        ref_p  <= '0;
        match  <= '0;
        locked <= 1'b0;
      end else begin
        if (rise && state != SR_IDLE) edge_cnt <= edge_cnt + 8'd1;
        if (tmo) begin
          err_sticky <= 1'b1;
          locked     <= 1'b0;
          state      <= SR_SEEK;
        end else begin
          case (state)
            SR_IDLE: state <= SR_SEEK;
            SR_SEEK: if (rise) state <= SR_MEASURE;
            SR_MEASURE: if (rise) begin
              ref_p <= interval;
              match <= '0;
              state <= SR_TRACK;
            end
            SR_TRACK: if (rise) begin
              if (hit) begin
                match <= match + MW'(1);
                if (match == MW'(LOCK_COUNT - 1)) begin
                  state  <= SR_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                ref_p <= interval;
                match <= '0;
              end
            end
            SR_LOCKED: if (rise && !hit) begin
              err_sticky <= 1'b1;
              ref_p      <= interval;
              match      <= '0;
              locked     <= 1'b0;
              state      <= SR_TRACK;
            end
            default: state <= SR_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sysref_monitor.sv
// Directed + randomized SYSREF bench against an edge/interval-level reference model.
module tb_sysref_monitor;

  localparam int PW   = 8;
  localparam int LC   = 4;
  localparam int TL   = 1;
  localparam int MAXC = (1 << PW) - 1;

  logic          pl_clk = 1'b0;
  logic          pl_rst = 1'b1;
  logic          sysref_in = 1'b1;
  logic          enable = 1'b0;
  logic          clear_err = 1'b0;
  logic          sysref_edge, locked, err_sticky;
  logic [PW-1:0] period, phase;
  logic [7:0]    edge_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model: cycles since last edge, edges seen since arming, matching run.
  int m_prev, m_el, m_seen, m_ref, m_run, m_ecnt;
  bit m_armed, m_lock, m_err, m_edge;

  always #5 pl_clk = ~pl_clk;

  sysref_monitor #(.PERIOD_W(PW), .LOCK_COUNT(LC), .TOL(TL)) dut (
    .pl_clk      (pl_clk),
    .pl_rst      (pl_rst),
    .sysref_in   (sysref_in),
    .enable      (enable),
    .clear_err   (clear_err),
    .sysref_edge (sysref_edge),
    .locked      (locked),
    .period      (period),
    .phase       (phase),
    .err_sticky  (err_sticky),
    .edge_cnt    (edge_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_step();
    bit e, tmo, set;
    int iv, d;
    if (pl_rst) begin
      m_prev = 1; m_el = 0; m_armed = 0; m_seen = 0; m_ref = 0; m_run = 0;
      m_lock = 0; m_err = 0; m_ecnt = 0; m_edge = 0;
      return;
    end
    e   = sysref_in && (m_prev == 0);
    iv  = m_el + 1;
    tmo = m_armed && (m_seen >= 1) && (m_el == MAXC);
    set = 0;
    if (!enable) begin
      m_armed = 0; m_seen = 0; m_ref = 0; m_run = 0; m_lock = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else begin
      if (e) m_ecnt = (m_ecnt + 1) % 256;
      if (tmo) begin
        set = 1; m_seen = 0; m_lock = 0;
      end else if (e) begin
        d = iv - m_ref;
        if (d < 0) d = -d;
        if (m_seen == 0) m_seen = 1;
        else if (m_seen == 1) begin m_seen = 2; m_ref = iv; m_run = 0; end
        else if (d <= TL) begin
          if (!m_lock) begin
            m_run++;
            if (m_run == LC) m_lock = 1;
          end
        end else begin
          if (m_lock) set = 1;
          m_lock = 0; m_ref = iv; m_run = 0;
        end
      end
    end
    if (set) m_err = 1;
    else if (clear_err) m_err = 0;
    m_edge = e;
    m_el   = e ? 0 : ((m_el < MAXC) ? m_el + 1 : MAXC);
    m_prev = sysref_in;
  endtask

  task automatic cyc();
    @(posedge pl_clk);
    m_step();
    @(negedge pl_clk);
    chk("edge", sysref_edge, m_edge);
    chk("phase", phase, m_el);
    chk("locked", locked, m_lock);
    chk("err", err_sticky, m_err);
    chk("ecnt", edge_cnt, m_ecnt);
    if (m_lock) chk("period", period, m_ref);
  endtask

  task automatic rest(input int p);
    int hi;
    hi = 1 + $urandom_range(0, p / 2 - 1);
    for (int i = 1; i < p; i++) begin
      sysref_in = (i < hi);
      cyc();
    end
  endtask

  task automatic pulse(input int p);
    sysref_in = 1'b1;
    cyc();
    rest(p);
  endtask

  initial begin
    int p;
    // Reset with SYSREF already high, then hold it high: no edge may appear.
    repeat (3) cyc();
    chk("rst_edge", sysref_edge, 0);
    chk("rst_locked", locked, 0);
    chk("rst_period", period, 0);
    chk("rst_phase", phase, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_ecnt", edge_cnt, 0);
    pl_rst = 1'b0;
    repeat (20) cyc();
    chk("hi_noedge", sysref_edge, 0);
    chk("hi_ecnt", edge_cnt, 0);

    // Period 64: lock the cycle after the 6th edge.
    sysref_in = 1'b0; enable = 1'b1;
    repeat (4) cyc();
    repeat (5) pulse(64);
    chk("prelock", locked, 0);
    sysref_in = 1'b1; cyc();
    chk("lock6", locked, 1);
    chk("period64", period, 64);
    chk("phase0", phase, 0);
    rest(64);
    chk("phase63", phase, 63);

    // Jitter within tolerance keeps lock; a 70 breaks it.
    for (int i = 0; i < 8; i++) pulse((i % 2) ? 65 : 63);
    chk("jit_lock", locked, 1);
    chk("jit_err", err_sticky, 0);
    pulse(70);
    sysref_in = 1'b1; cyc();
    chk("mm_lock", locked, 0);
    chk("mm_err", err_sticky, 1);
    rest(70);
    repeat (3) pulse(70);
    chk("relock_pre", locked, 0);
    sysref_in = 1'b1; cyc();
    chk("relock", locked, 1);
    chk("period70", period, 70);
    rest(70);

    // Loss of SYSREF while locked.
    clear_err = 1'b1; cyc(); clear_err = 1'b0;
    chk("clr1", err_sticky, 0);
    sysref_in = 1'b0;
    repeat (150) cyc();
    chk("tmo_pre_lock", locked, 1);
    chk("tmo_pre_err", err_sticky, 0);
    repeat (120) cyc();
    chk("tmo_lock", locked, 0);
    chk("tmo_err", err_sticky, 1);
    repeat (7) pulse(64);
    chk("tmo_relock", locked, 1);

    // Clear coinciding with a mismatch error.
    clear_err = 1'b1; cyc(); clear_err = 1'b0;
    chk("clr2", err_sticky, 0);
    pulse(80);
    sysref_in = 1'b1; clear_err = 1'b1; cyc(); clear_err = 1'b0;
    chk("clr_vs_err", err_sticky, 1);
    rest(80);
    clear_err = 1'b1; cyc(); clear_err = 1'b0;
    chk("clr3", err_sticky, 0);
    repeat (5) pulse(80);
    chk("lock80", locked, 1);

    // Enable dropped on a mismatch edge: IDLE wins, no error.
    pulse(90);
    sysref_in = 1'b1; enable = 1'b0; cyc();
    chk("drop_lock", locked, 0);
    chk("drop_err", err_sticky, 0);
    rest(90);
    chk("drop_idle_lock", locked, 0);

    // Mid-operation reset, then 300 edges wrap edge_cnt to 44.
    pl_rst = 1'b1; cyc();
    chk("mrst_ecnt", edge_cnt, 0);
    chk("mrst_phase", phase, 0);
    pl_rst = 1'b0; sysref_in = 1'b0; enable = 1'b1;
    repeat (2) cyc();
    repeat (300) pulse(4);
    chk("ecnt44", edge_cnt, 44);

    // Randomized periods, jitter, losses, clears and enable drops.
    for (int k = 0; k < 60; k++) begin
      p = 20 + $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) p = 30 + $urandom_range(0, 20);
      if ($urandom_range(0, 19) == 0) p = 300;
      sysref_in = 1'b1;
      clear_err = ($urandom_range(0, 7) == 0);
      enable    = ($urandom_range(0, 29) != 0);
      cyc();
      clear_err = 1'b0; enable = 1'b1;
      rest(p);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sysref_monitor.md
# sysref_monitor

Qualifies the registered PL SYSREF produced by the SYSREF capture stage in the `pl_clk` domain. It detects rising edges and measures the SYSREF period. It declares lock after a run of consistent periods and flags missing or irregular SYSREF. Its outputs drive the RF-ADC/RF-DAC sync sequencing logic and are visible to software through status registers.

## Interface
Parameters:
- `PERIOD_W`, 16: width of the interval counter and period fields.
- `LOCK_COUNT`, 4: number of consecutive matching intervals required for lock (≥1).
- `TOL`, 1: allowed interval deviation, in cycles (absorbs asynchronous-capture jitter).

Ports:
- `pl_clk` in 1: the single clock; the same clock that registers SYSREF upstream.
- `pl_rst` in 1: synchronous, active-high reset.
- `sysref_in` in 1: registered SYSREF from the capture stage.
- `enable` in 1: level input; monitoring runs while it is high.
- `clear_err` in 1: single-cycle pulse that clears `err_sticky`.
- `sysref_edge` out 1: one-cycle pulse per detected rising edge.
- `locked` out 1: SYSREF period is stable.
- `period` out `PERIOD_W`: reference interval, in cycles. Meaningful only while `locked` is high.
- `phase` out `PERIOD_W`: cycles elapsed since the last edge.
- `err_sticky` out 1: a loss or mismatch occurred since the last clear.
- `edge_cnt` out 8: count of edges seen while enabled. Wraps from 255 to 0.

## Operation
- Edge detect: `sref_d` ← `sysref_in` each cycle. A rising edge is `sysref_in & ~sref_d`. `sref_d` resets to 1, so an input that is already high at reset release produces no edge.
- Interval counter `cnt`:
  - Cleared to 0 on an edge cycle.
  - Otherwise increments, saturating at 2^`PERIOD_W`−1.
  - Measured interval = `cnt`+1, so edges at cycles 0 and P give an interval of P.
- A mismatch means |interval − `ref`| > `TOL`.
- State machine states: IDLE, SEEK, MEASURE, TRACK, LOCKED.
  - IDLE: `enable` → SEEK.
  - SEEK: edge → MEASURE.
  - MEASURE: edge → `ref` ← interval, `match` ← 0, go to TRACK.
  - TRACK, edge with a match: `match`++. When `match` reaches `LOCK_COUNT`, go to LOCKED.
  - TRACK, edge with a mismatch: `ref` ← interval, `match` ← 0, stay in TRACK. No error is raised (lock has not yet been claimed).
  - LOCKED, edge with a match: stay in LOCKED.
  - LOCKED, edge with a mismatch: set `err_sticky`, `ref` ← interval, `match` ← 0, go to TRACK.
- Timeout: `cnt` saturates in MEASURE, TRACK or LOCKED → set `err_sticky` and go to SEEK.
- `enable` low in any state → IDLE. `ref`, `match` and `locked` are cleared. `err_sticky` and `edge_cnt` hold.
- `sysref_edge` pulses in every state. `edge_cnt` increments only while `enable` is high and the state is not IDLE.
- Simultaneous events:
  - `enable` low together with an edge or an error: IDLE wins and no error is set.
  - `clear_err` together with a new error: the error wins and `err_sticky` stays 1.

## Timing
- All outputs are registered. Reset values: `sysref_edge`=0, `locked`=0, `period`=0, `phase`=0, `err_sticky`=0, `edge_cnt`=0. State resets to IDLE.
- Edge latency: `sysref_in` rises in cycle N (low in N−1) → `sysref_edge`=1 in cycle N+1, for exactly one cycle.
- `phase` = `cnt` registered. It reads 0 in cycle N+1 after an edge in cycle N.
- `locked` rises in the cycle after the qualifying edge's state update, i.e. N+1 for the edge in cycle N. `period` updates in the same cycle.
- `locked` falls at N+1 on a mismatch edge in cycle N, or the cycle after a timeout.
- Reset asserted mid-operation: all state returns to reset values on the next edge of `pl_clk`.

## Structure
- Package `sysref_pkg` holds:
  - the state enum (`SR_IDLE`, `SR_SEEK`, `SR_MEASURE`, `SR_TRACK`, `SR_LOCKED`);
  - default width constants;
  - the tolerance-compare function.
- Sub-module `sysref_edge_det` contains `sref_d`, the edge pulse and `cnt` with saturation.
- The top level contains the state machine, `ref`/`match`, the error logic and the output registers.

## Test plan
- Reset release with `sysref_in`=1 held → no `sysref_edge` and `edge_cnt`=0 after 20 cycles.
- `enable`=1, SYSREF period 64 with LOCK_COUNT=4:
  - `locked` rises the cycle after the 6th edge;
  - `period`=64;
  - `phase` sweeps 0..63.
- While locked, alternate intervals 63/65 with TOL=1 → stays locked, `err_sticky`=0. One interval of 70 → `locked` drops, `err_sticky`=1, state TRACK, then relock after 4 further matching intervals.
- PERIOD_W=8, stop SYSREF while locked → `err_sticky`=1 and state SEEK when `cnt` reaches 255. Restarting SYSREF relocks.
- Assert `clear_err` in the same cycle as a mismatch error → `err_sticky` stays 1. `clear_err` alone afterwards → 0.
- Drop `enable` in the cycle of a mismatch edge → state IDLE, `locked`=0, `err_sticky` unchanged. Separately, 300 edges while enabled → `edge_cnt`=44.
